// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing controller for a five-stage
// (IF/ID/EX/MEM/WB) pipeline.
//   - Keeps a valid bit per downstream stage (ID, EX, MEM, WB) so that
//     bubbles and flushed slots never stall, forward or redirect.
//   - Detects load-use hazards (load in EX feeding the ID instruction) and
//     stalls PC + IF/ID for one cycle while a NOP enters ID/EX.
//   - Resolves taken branches in EX from Zero: redirects the PC and flushes
//     IF/ID and ID/EX. A taken branch overrides a simultaneous load-use.
//   - Drives EX operand forwarding selects (MEM result beats WB result).
//   - Keeps saturating stall / flush event counters.
// Ports:
//   clk, rst                    clock, async active-high reset
//   id_rs, id_rt, id_ReadRt     ID source registers / rt-is-source flag
//   ex_rs, ex_rt, ex_rw         EX sources and destination
//   ex_RegWr, ex_MemtoReg       EX writes a register / EX is a load
//   ex_Branch, ex_Zero          EX is a conditional branch / ALU Zero
//   mem_rw, mem_RegWr           MEM destination and write enable
//   wb_rw, wb_RegWr             WB destination and write enable
//   pc_stall, ifid_stall        hold PC / hold IF/ID
//   idex_bubble                 load NOP into ID/EX
//   flush                       clear IF/ID and ID/EX
//   pc_sel                      PC takes branch target
//   fwdA, fwdB                  00 regfile, 01 MEM result, 10 WB result
//   stall_cnt, flush_cnt        saturating event counters
module hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_ReadRt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rw,
    input  logic             ex_RegWr,
    input  logic             ex_MemtoReg,
    input  logic             ex_Branch,
    input  logic             ex_Zero,
    input  logic [4:0]       mem_rw,
    input  logic [4:0]       wb_rw,
    input  logic             mem_RegWr,
    input  logic             wb_RegWr,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_bubble,
    output logic             flush,
    output logic             pc_sel,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic v_id_q,  v_id_d;
    logic v_ex_q,  v_ex_d;
    logic v_mem_q, v_mem_d;
    logic v_wb_q,  v_wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic take;
    logic luse;
    logic mem_fwd_ok;
    logic wb_fwd_ok;

    always_comb begin
        take = v_ex_q && ex_Branch && ex_Zero;
        luse = v_id_q && v_ex_q && ex_MemtoReg && ex_RegWr && (ex_rw != 5'd0) &&
               ((ex_rw == id_rs) || (id_ReadRt && (ex_rw == id_rt)));
    end

    // Taken branch wins: the ID instruction that would stall is being flushed.
    always_comb begin
        pc_sel      = 1'b0;
        flush       = 1'b0;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_bubble = 1'b0;
        if (take) begin
            pc_sel = 1'b1;
            flush  = 1'b1;
        end else if (luse) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    // Register 0 is hard-wired, so a write to it is never a forwarding source.
    always_comb begin
        mem_fwd_ok = v_mem_q && mem_RegWr && (mem_rw != 5'd0);
        wb_fwd_ok  = v_wb_q && wb_RegWr && (wb_rw != 5'd0);

        fwdA = 2'b00;
        if (mem_fwd_ok && (mem_rw == ex_rs)) begin
            fwdA = 2'b01;
        end else if (wb_fwd_ok && (wb_rw == ex_rs)) begin
            fwdA = 2'b10;
        end

        fwdB = 2'b00;
        if (mem_fwd_ok && (mem_rw == ex_rt)) begin
            fwdB = 2'b01;
        end else if (wb_fwd_ok && (wb_rw == ex_rt)) begin
            fwdB = 2'b10;
        end
    end

    always_comb begin
        v_wb_d      = v_mem_q;
        v_mem_d     = v_ex_q;
        v_ex_d      = v_id_q;
        v_id_d      = 1'b1;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (take) begin
            v_ex_d = 1'b0;
            v_id_d = 1'b0;
            if (flush_cnt_q != '1) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end else if (luse) begin
            v_ex_d = 1'b0;
            v_id_d = v_id_q;
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_id_q      <= 1'b0;
            v_ex_q      <= 1'b0;
            v_mem_q     <= 1'b0;
            v_wb_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            v_id_q      <= v_id_d;
            v_ex_q      <= v_ex_d;
            v_mem_q     <= v_mem_d;
            v_wb_q      <= v_wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// behavioural pipeline-occupancy model. A second instance with a narrow
// counter exercises saturation within a short run.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rw, mem_rw, wb_rw;
    logic       id_ReadRt, ex_RegWr, ex_MemtoReg, ex_Branch, ex_Zero;
    logic       mem_RegWr, wb_RegWr;

    logic        pc_stall, ifid_stall, idex_bubble, flush, pc_sel;
    logic [1:0]  fwdA, fwdB;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_stall, s_ifid_stall, s_idex_bubble, s_flush, s_pc_sel;
    logic [1:0]  s_fwdA, s_fwdB;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_ReadRt(id_ReadRt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rw(ex_rw),
        .ex_RegWr(ex_RegWr), .ex_MemtoReg(ex_MemtoReg),
        .ex_Branch(ex_Branch), .ex_Zero(ex_Zero),
        .mem_rw(mem_rw), .wb_rw(wb_rw),
        .mem_RegWr(mem_RegWr), .wb_RegWr(wb_RegWr),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_bubble(idex_bubble),
        .flush(flush), .pc_sel(pc_sel), .fwdA(fwdA), .fwdB(fwdB),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_ReadRt(id_ReadRt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rw(ex_rw),
        .ex_RegWr(ex_RegWr), .ex_MemtoReg(ex_MemtoReg),
        .ex_Branch(ex_Branch), .ex_Zero(ex_Zero),
        .mem_rw(mem_rw), .wb_rw(wb_rw),
        .mem_RegWr(mem_RegWr), .wb_RegWr(wb_RegWr),
        .pc_stall(s_pc_stall), .ifid_stall(s_ifid_stall), .idex_bubble(s_idex_bubble),
        .flush(s_flush), .pc_sel(s_pc_sel), .fwdA(s_fwdA), .fwdB(s_fwdB),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // occ[k]: slot k of the pipe holds a real instruction (0=ID,1=EX,2=MEM,3=WB)
    bit     occ [4];
    longint m_stalls, m_flushes;

    function automatic bit m_take();
        return occ[1] && ex_Branch && ex_Zero;
    endfunction

    function automatic bit m_luse();
        bit dep;
        dep = (ex_rw == id_rs) || (id_ReadRt && ex_rw == id_rt);
        return occ[0] && occ[1] && ex_MemtoReg && ex_RegWr && ex_rw != 0 && dep;
    endfunction

    function automatic int m_fwd(input logic [4:0] src);
        if (src == 0) return 0;
        if (occ[2] && mem_RegWr && mem_rw == src) return 1;
        if (occ[3] && wb_RegWr && wb_rw == src) return 2;
        return 0;
    endfunction

    function automatic longint sat(input longint n, input int w);
        longint lim;
        lim = (longint'(1) << w) - 1;
        return (n > lim) ? lim : n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) occ[k] <= 1'b0;
            m_stalls  <= 0;
            m_flushes <= 0;
        end else begin
            occ[3] <= occ[2];
            occ[2] <= occ[1];
            if (m_take()) begin
                occ[1] <= 1'b0;
                occ[0] <= 1'b0;
                m_flushes <= m_flushes + 1;
            end else if (m_luse()) begin
                occ[1] <= 1'b0;
                m_stalls <= m_stalls + 1;
            end else begin
                occ[1] <= occ[0];
                occ[0] <= 1'b1;
            end
        end
    end

    // ---------------- every-cycle comparison ----------------
    always @(negedge clk) begin
        bit t, l;
        t = m_take();
        l = m_luse() && !t;
        chk("pc_sel",      pc_sel,      t);
        chk("flush",       flush,       t);
        chk("pc_stall",    pc_stall,    l);
        chk("ifid_stall",  ifid_stall,  l);
        chk("idex_bubble", idex_bubble, l);
        chk("fwdA",        fwdA,        m_fwd(ex_rs));
        chk("fwdB",        fwdB,        m_fwd(ex_rt));
        chk("stall_cnt",   stall_cnt,   sat(m_stalls, 16));
        chk("flush_cnt",   flush_cnt,   sat(m_flushes, 16));
        chk("s_stall_cnt", s_stall_cnt, sat(m_stalls, 4));
        chk("s_flush_cnt", s_flush_cnt, sat(m_flushes, 4));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_ReadRt = 0;
        ex_rs = 0; ex_rt = 0; ex_rw = 0;
        ex_RegWr = 0; ex_MemtoReg = 0; ex_Branch = 0; ex_Zero = 0;
        mem_rw = 0; wb_rw = 0; mem_RegWr = 0; wb_RegWr = 0;
    endtask

    // lw $3 in EX, add $4,$3,$5 in ID
    task automatic load_use();
        ex_MemtoReg = 1; ex_RegWr = 1; ex_rw = 3;
        id_rs = 3; id_rt = 5; id_ReadRt = 1;
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        clear_inputs();
        repeat (2) tick();
        chk("rst_pc_stall", pc_stall, 0);
        chk("rst_flush",    flush,    0);
        chk("rst_pc_sel",   pc_sel,   0);
        chk("rst_fwdA",     fwdA,     0);
        chk("rst_cnt",      stall_cnt, 0);

        // Release with a hazard pattern already present: no stall until v_ex.
        load_use();
        ex_rs = 3;
        rst = 1'b0;
        tick();                                  // edge 1: ID valid only
        chk("edge1_nostall", pc_stall, 0);
        tick();                                  // edge 2: EX valid -> stall
        chk("lu_pc_stall",    pc_stall,    1);
        chk("lu_ifid_stall",  ifid_stall,  1);
        chk("lu_idex_bubble", idex_bubble, 1);
        chk("lu_flush",       flush,       0);
        tick();                                  // load now in MEM
        mem_rw = 3; mem_RegWr = 1;
        #1;
        chk("post_lu_nostall", pc_stall,  0);
        chk("post_lu_fwdA",    fwdA,      1);
        chk("post_lu_cnt",     stall_cnt, 1);

        tick();                                  // EX valid again, branch + load-use
        ex_Branch = 1; ex_Zero = 1;
        #1;
        chk("br_pc_sel",   pc_sel,   1);
        chk("br_flush",    flush,    1);
        chk("br_pc_stall", pc_stall, 0);
        chk("br_ifid",     ifid_stall, 0);
        tick();
        chk("br_flush_cnt", flush_cnt, 1);
        chk("br_stall_cnt", stall_cnt, 1);
        chk("br_one_cycle", pc_sel,    0);
        tick();
        chk("br_slot2",     pc_sel,    0);
        tick();
        chk("br_refill",    pc_sel,    1);
        clear_inputs();

        repeat (5) tick();
        mem_rw = 7; wb_rw = 7; mem_RegWr = 1; wb_RegWr = 1;
        ex_rs = 7; ex_rt = 7;
        #1;
        chk("fwd_pri_A", fwdA, 1);
        chk("fwd_pri_B", fwdB, 1);
        mem_rw = 0;
        #1;
        chk("fwd_wb_A", fwdA, 2);
        wb_rw = 0;
        #1;
        chk("fwd_r0_A", fwdA, 0);
        chk("fwd_r0_B", fwdB, 0);
        clear_inputs();

        // Many load-use events: narrow counter must stick at all-ones.
        load_use();
        repeat (2 * 19 + 4) tick();
        chk("sat_small", s_stall_cnt, 15);

        // Async reset in the middle of a stall.
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = pc_stall;
        end
        chk("stall_wait", seen, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_pc_stall", pc_stall,    0);
        chk("arst_bubble",   idex_bubble, 0);
        chk("arst_scnt",     stall_cnt,   0);
        chk("arst_fcnt",     flush_cnt,   0);
        chk("arst_s_scnt",   s_stall_cnt, 0);
        tick();
        rst = 1'b0;

        // Randomized traffic on a small register window to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            tick();
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            id_ReadRt   = 1'($urandom);
            ex_rs       = 5'($urandom_range(0, 3));
            ex_rt       = 5'($urandom_range(0, 3));
            ex_rw       = 5'($urandom_range(0, 3));
            ex_RegWr    = 1'($urandom);
            ex_MemtoReg = 1'($urandom);
            ex_Branch   = ($urandom_range(0, 3) == 0);
            ex_Zero     = 1'($urandom);
            mem_rw      = 5'($urandom_range(0, 3));
            wb_rw       = 5'($urandom_range(0, 3));
            mem_RegWr   = 1'($urandom);
            wb_RegWr    = 1'($urandom);
            if (i == 1500) rst = 1'b1;
            if (i == 1502) rst = 1'b0;
        end

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage datapath (IF, ID, EX, MEM, WB). It keeps one valid bit per stage, detects load-use hazards and stalls for them, and resolves taken branches from the execute stage's `Zero` flag, issuing the PC redirect and the flush. It also drives the forwarding selects for the execute stage's `busA`/`busB` operand muxes and keeps saturating stall and flush counters for debug.

## Interface
Parameters:
- `CNT_W`, default 16: width of the stall and flush counters.

Ports:
- `clk` — input, 1: clock; all state updates on the rising edge.
- `rst` — input, 1: asynchronous reset, active-high.
- `id_rs`, `id_rt` — input, 5 each: source registers of the instruction in ID.
- `id_ReadRt` — input, 1: the ID instruction reads `rt` as a source.
- `ex_rs`, `ex_rt` — input, 5 each: source registers of the instruction in EX.
- `ex_rw` — input, 5: destination register of EX.
- `ex_RegWr` — input, 1: EX writes a register.
- `ex_MemtoReg` — input, 1: EX is a load.
- `ex_Branch` — input, 1: EX is a conditional branch.
- `ex_Zero` — input, 1: `Zero` from the execute unit.
- `mem_rw`, `wb_rw` — input, 5 each: destinations in MEM and WB.
- `mem_RegWr`, `wb_RegWr` — input, 1 each: MEM / WB write a register.
- `pc_stall` — output, 1: hold the PC.
- `ifid_stall` — output, 1: hold the IF/ID register.
- `idex_bubble` — output, 1: load a NOP into ID/EX.
- `flush` — output, 1: clear IF/ID and ID/EX.
- `pc_sel` — output, 1: the PC loads the branch `Target` instead of `pc_inc`.
- `fwdA`, `fwdB` — output, 2 each: operand source select. 00 = register file, 01 = MEM result, 10 = WB result.
- `stall_cnt`, `flush_cnt` — output, `CNT_W` each: event counters.

## Operation
Stage valid bits `v_id`, `v_ex`, `v_mem`, `v_wb` are internal registers and are all 0 after reset. They qualify every hazard check, so bubbles and flushed slots never stall, forward or redirect.

Combinational decisions (within a cycle):
- `take` = `v_ex` & `ex_Branch` & `ex_Zero`.
- `luse` = `v_id` & `v_ex` & `ex_MemtoReg` & `ex_RegWr` & (`ex_rw` != 0) & ((`ex_rw` == `id_rs`) | (`id_ReadRt` & (`ex_rw` == `id_rt`))).
- Priority: `take` overrides `luse`. When a taken branch is in EX, the load-use hazard in ID is discarded because that instruction is flushed.
- If `take`: `pc_sel`=1, `flush`=1, and `pc_stall`=`ifid_stall`=`idex_bubble`=0.
- If `luse` and not `take`: `pc_stall`=`ifid_stall`=`idex_bubble`=1, and `flush`=`pc_sel`=0.
- Otherwise all five of these outputs are 0.
- `fwdA`:
  - 01 if `v_mem` & `mem_RegWr` & `mem_rw`!=0 & `mem_rw`==`ex_rs`;
  - else 10 if `v_wb` & `wb_RegWr` & `wb_rw`!=0 & `wb_rw`==`ex_rs`;
  - else 00.
- `fwdB` uses the same rule with `ex_rt`. MEM wins over WB.
- Register 0 is never forwarded and never causes a stall.

Valid-bit update at each clock edge:
- `v_wb` <= `v_mem`; `v_mem` <= `v_ex`, unconditionally.
- If `take`: `v_ex` <= 0 and `v_id` <= 0 (flush). This leaves a two-slot penalty.
- Else if `luse`: `v_ex` <= 0 (bubble) and `v_id` holds.
- Else: `v_ex` <= `v_id` and `v_id` <= 1 (a new fetch is always valid).

Counters:
- `stall_cnt` increments on each cycle with `luse` & !`take`.
- `flush_cnt` increments on each cycle with `take`.
- Both saturate at all-ones and never wrap.

## Timing
- Every control output is combinational from the current inputs and state, with zero-cycle latency. The surrounding pipeline registers them at the same edge.
- Load-use costs exactly one stall cycle. In the next cycle the load is in MEM, `luse` deasserts, and `fwdA`/`fwdB`=01 supplies the loaded value.
- A taken branch costs two cycles. `pc_sel` is high for exactly one cycle per taken branch, because the following cycle sees `v_ex`=0.
- After reset is released, `v_id` becomes 1 on the first edge and `v_ex` on the second. No stall, flush or forward occurs before that.
- Reset values:
  - All valid bits and both counters are 0.
  - `pc_stall`, `ifid_stall`, `idex_bubble`, `flush` and `pc_sel` are 0.
  - `fwdA` and `fwdB` are 00.
- Reset asserted mid-stall or mid-flush clears everything immediately (asynchronously), with no pending state retained.
- A back-to-back load-use after a stall re-evaluates against the new EX contents. A bubble in EX never triggers a second stall.

## Test plan
- Reset release, with a NOP stream and no hazards:
  - all controls stay 0 and `fwdA`/`fwdB`=00;
  - `v_id` reaches 1 at the first edge and `v_ex` at the second.
- `lw $3` followed by `add $4,$3,$5`:
  - exactly one cycle of `pc_stall`=`ifid_stall`=`idex_bubble`=1;
  - the next cycle gives `fwdA`=01;
  - `stall_cnt`=1.
- `beq` in EX with `ex_Zero`=1, and a load-use hazard in ID in the same cycle:
  - `pc_sel`=`flush`=1 and `pc_stall`=0 for one cycle;
  - `flush_cnt`=1 and `stall_cnt` unchanged.
- Forwarding priority, MEM and WB both writing `$7` and EX reading `$7` as rs and rt:
  - `fwdA`=`fwdB`=01;
  - the same setup with `rw`=0 gives 00.
- Force 2^`CNT_W`+3 load-use events: `stall_cnt` holds at 0xFFFF (`CNT_W`=16).
- Assert `rst` during a stall cycle: all outputs drop to reset values in the same cycle, before the next edge.
